// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - shared types and phase constants for the quadrature encoder generator
package quad_enc_pkg;

  // Run state of the generator
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Quadrature phases as {A,B}; forward walks PH0 -> PH1 -> PH2 -> PH3 -> PH0
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  // Direction encoding matches the sign bit of the commanded step count
  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  // Neighbouring phase in the given direction; only one of A/B ever differs
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    nxt = PH0;
    case (ph)
      PH0: nxt = (dir == FWD) ? PH1 : PH3;
      PH1: nxt = (dir == FWD) ? PH2 : PH0;
      PH2: nxt = (dir == FWD) ? PH3 : PH1;
      PH3: nxt = (dir == FWD) ? PH0 : PH2;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_enc_phase_step.sv
// rtl/quad_enc_phase_step.sv - registered two-bit quadrature phase stepper
module quad_enc_phase_step
  import quad_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_step,
  input  logic       i_dir,
  output logic [1:0] o_ab
);

  logic [1:0] r_ab;

  // Advance one quadrature edge per strobe; the phase is kept between runs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ab <= PH0;
    end else if (i_step) begin
      r_ab <= next_phase(r_ab, i_dir);
    end
  end

  assign o_ab = r_ab;

endmodule

// File: rtl/quad_enc_gen.sv
// rtl/quad_enc_gen.sv - quadrature A/B generator driven by signed step commands
module quad_enc_gen
  import quad_enc_pkg::*;
#(
  parameter int STEP_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int POS_WIDTH    = 32,
  parameter int MIN_PERIOD   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic signed [STEP_WIDTH-1:0] cmd_steps,
  input  logic [PERIOD_WIDTH-1:0]      cmd_period,
  input  logic                         abort,
  output logic                         enc_a,
  output logic                         enc_b,
  output logic                         busy,
  output logic                         done,
  output logic signed [POS_WIDTH-1:0]  position
);

  state_t                       r_state;
  logic [PERIOD_WIDTH-1:0]      r_timer;
  logic [PERIOD_WIDTH-1:0]      r_period;
  logic [STEP_WIDTH-1:0]        r_remaining;
  logic                         r_dir;
  logic                         r_ready;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_zero_pend;
  logic signed [POS_WIDTH-1:0]  r_pos;

  logic                         w_accept;
  logic [STEP_WIDTH-1:0]        w_mag;
  logic [PERIOD_WIDTH-1:0]      w_period;
  logic                         w_expire;
  logic                         w_step;
  logic                         w_last;
  logic [1:0]                   w_ab;

  // Magnitude is taken as unsigned so the most negative count keeps its full size
  assign w_accept = cmd_valid && r_ready;
  assign w_mag    = cmd_steps[STEP_WIDTH-1] ? STEP_WIDTH'(-cmd_steps) : STEP_WIDTH'(cmd_steps);
  assign w_period = (cmd_period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : cmd_period;

  // Abort takes priority over an expiring timer, so no edge slips out on abort
  assign w_expire = (r_state == RUN) && (r_timer == '0);
  assign w_step   = w_expire && !abort;
  assign w_last   = (r_remaining == STEP_WIDTH'(1));

  quad_enc_phase_step u_phase (
    .i_clk   (clk),
    .i_reset (reset),
    .i_step  (w_step),
    .i_dir   (r_dir),
    .o_ab    (w_ab)
  );

  // Run control: command capture, edge timer, remaining count and position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_period    <= '0;
      r_remaining <= '0;
      r_dir       <= FWD;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
      r_pos       <= '0;
    end else begin
      // A zero-step command reports completion one cycle after it is taken
      r_done      <= r_zero_pend;
      r_zero_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_mag == '0) begin
              r_zero_pend <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_ready     <= 1'b0;
              r_busy      <= 1'b1;
              r_remaining <= w_mag;
              r_dir       <= cmd_steps[STEP_WIDTH-1];
              r_period    <= w_period;
              r_timer     <= w_period - PERIOD_WIDTH'(1);
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_timer <= '0;
          end else if (w_expire) begin
            r_pos       <= (r_dir == REV) ? r_pos - POS_WIDTH'(1) : r_pos + POS_WIDTH'(1);
            r_remaining <= r_remaining - STEP_WIDTH'(1);
            r_timer     <= r_period - PERIOD_WIDTH'(1);
            if (w_last) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_timer <= '0;
            end
          end else begin
            r_timer <= r_timer - PERIOD_WIDTH'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign position  = r_pos;
  assign enc_a     = w_ab[1];
  assign enc_b     = w_ab[0];

endmodule

// File: tb/tb_quad_enc_gen.sv
// tb/tb_quad_enc_gen.sv - self-checking bench for quad_enc_gen
module tb_quad_enc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        enc_a, enc_b, busy, done;
  logic [31:0] position;

  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [7:0]  s_cmd_steps = '0;
  logic [3:0]  s_cmd_period = '0;
  logic        s_enc_a, s_enc_b, s_busy, s_done;
  logic [7:0]  s_position;

  quad_enc_gen dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done), .position(position)
  );

  quad_enc_gen #(.STEP_WIDTH(8), .PERIOD_WIDTH(4), .POS_WIDTH(8), .MIN_PERIOD(2)) dut_small (
    .clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_steps(s_cmd_steps), .cmd_period(s_cmd_period), .abort(1'b0),
    .enc_a(s_enc_a), .enc_b(s_enc_b), .busy(s_busy), .done(s_done), .position(s_position)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase index into the forward sequence and signed edge total
  logic [1:0]  tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          m_idx = 0;
  logic [31:0] m_pos = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mod4(input int x);
    return ((x % 4) + 4) % 4;
  endfunction

  // Every observed A/B change must flip exactly one line (reset jumps excepted)
  logic [1:0] prev_ab = 2'b00, prev_sab = 2'b00;
  logic       last_rst = 1'b1;
  always @(posedge clk) last_rst <= reset;
  always @(negedge clk) begin
    if (!last_rst && ({enc_a, enc_b} !== prev_ab))
      check("single_bit_change", 32'($countones({enc_a, enc_b} ^ prev_ab)), 32'd1);
    if (!last_rst && ({s_enc_a, s_enc_b} !== prev_sab))
      check("single_bit_change_small", 32'($countones({s_enc_a, s_enc_b} ^ prev_sab)), 32'd1);
    prev_ab  = {enc_a, enc_b};
    prev_sab = {s_enc_a, s_enc_b};
  end

  // One command: abort_edge is the clock edge on which abort is sampled (0 = none)
  task automatic run_cmd(input int steps, input int period, input int abort_edge, input bit idle_abort);
    int n, sgn, p, fin, e, lim;
    n   = (steps < 0) ? -steps : steps;
    sgn = (steps < 0) ? -1 : 1;
    p   = (period < 2) ? 2 : period;
    fin = (n == 0) ? 1 : n * p;
    if (n != 0 && abort_edge > 0 && abort_edge <= n * p) fin = abort_edge;
    check("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_steps  = steps[15:0];
    cmd_period = period[15:0];
    abort      = idle_abort;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    cmd_steps  = 16'($urandom);
    cmd_period = 16'($urandom);
    e = 0;
    for (int c = 0; c <= fin + 1; c++) begin
      lim = c / p;
      if (lim > n) lim = n;
      if (n != 0 && abort_edge > 0 && abort_edge <= n * p && lim > (abort_edge - 1) / p)
        lim = (abort_edge - 1) / p;
      e = lim;
      check("ab",       {30'b0, enc_a, enc_b}, {30'b0, tab[mod4(m_idx + sgn * e)]});
      check("position", position, m_pos + 32'(sgn * e));
      check("busy",     {31'b0, busy},      {31'b0, (n != 0) && (c < fin)});
      check("ready",    {31'b0, cmd_ready}, {31'b0, !((n != 0) && (c < fin))});
      check("done",     {31'b0, done},      {31'b0, c == fin});
      if (c == fin + 1) break;
      if (abort_edge > 0 && c == abort_edge - 1) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    m_idx = mod4(m_idx + sgn * e);
    m_pos = m_pos + 32'(sgn * e);
  endtask

  initial begin
    int st, pr, ab, n, p, k;
    bit got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ab",    {30'b0, enc_a, enc_b}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_pos",   position, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("idle_ab",   {30'b0, enc_a, enc_b}, 32'd0);
    check("idle_ready",{31'b0, cmd_ready}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_pos",  position, 32'd0);

    run_cmd(4, 3, 0, 1'b0);
    run_cmd(-2, 5, 0, 1'b0);
    run_cmd(2, 2, 0, 1'b0);
    run_cmd(3, 0, 0, 1'b0);
    run_cmd(0, 7, 0, 1'b0);
    run_cmd(10, 4, 10, 1'b0);
    run_cmd(10, 4, 12, 1'b0);
    run_cmd(1, 2, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      st = int'($urandom_range(0, 40)) - 20;
      pr = int'($urandom_range(0, 6));
      n  = (st < 0) ? -st : st;
      p  = (pr < 2) ? 2 : pr;
      ab = 0;
      if (n != 0 && ($urandom % 3) == 0) ab = int'($urandom_range(1, n * p));
      run_cmd(st, pr, ab, 1'b0);
    end

    cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrst_ab",    {30'b0, enc_a, enc_b}, 32'd0);
    check("midrst_pos",   position, 32'd0);
    check("midrst_busy",  {31'b0, busy}, 32'd0);
    check("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    m_idx = 0;
    m_pos = '0;
    @(posedge clk); #1;

    run_cmd(-32768, 2, 0, 1'b0);
    check("big_final_ab",  {30'b0, enc_a, enc_b}, 32'd0);
    check("big_final_pos", position, 32'hFFFF_8000);

    for (int r = 0; r < 2; r++) begin
      s_cmd_valid  = 1'b1;
      s_cmd_steps  = (r == 0) ? 8'd127 : 8'd1;
      s_cmd_period = 4'd2;
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
      got = 1'b0;
      k = 0;
      while (!got && k < 400) begin
        @(posedge clk); #1;
        got = s_done;
        k++;
      end
      check("wrap_done_seen", {31'b0, got}, 32'd1);
      check("wrap_pos", {24'b0, s_position}, (r == 0) ? 32'h7F : 32'h80);
    end
    check("wrap_ab", {30'b0, s_enc_a, s_enc_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
